vec_op_sequencer: RTL and testbench

// Multi-cycle controller/datapath sequencer for the vector arithmetic ops
// (add, sub, constant add/sub, poly y = x/2 + x + x*x). Sits between a

---
 rtl/vec_op_sequencer_if.sv | 36 +++
 rtl/vec_op_sequencer.sv | 229 ++++++++++++++++++++++
 tb/tb_vec_op_sequencer.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/vec_op_sequencer_if.sv
// vec_op_sequencer_if
//
// Request/response bundle between a requester and vec_op_sequencer.
//
//   start   requester -> sequencer   request, sampled only while idle
//   op      requester -> sequencer   3-bit op code
//   a, b    requester -> sequencer   W-bit operands
//   busy    sequencer -> requester   high whenever an op is in flight
//   done    sequencer -> requester   one-cycle completion pulse
//   err     sequencer -> requester   illegal op flag, valid with done
//   result  sequencer -> requester   2W-bit result, held until next accept
//
// master: the requester side.  slave: the sequencer side.

interface vec_op_sequencer_if #(
  parameter int W = 8
);
  logic             start;
  logic [2:0]       op;
  logic [W-1:0]     a;
  logic [W-1:0]     b;
  logic             busy;
  logic             done;
  logic             err;
  logic [2*W-1:0]   result;

  modport master (
    output start, op, a, b,
    input  busy, done, err, result
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, err, result
  );
endinterface

// File: rtl/vec_op_sequencer.sv
// vec_op_sequencer
//
// Multi-cycle sequencer for the vector arithmetic ops. One op is in flight
// at a time. Every 2W-bit add (ALU ops, multiply iterations, final poly
// accumulate) goes through a single shared adder; x*x for POLY is done by
// a W-cycle LSB-first shift-add multiply.
//
//   op 0 ADD  : a + b
//   op 1 SUB  : b - a
//   op 2 CADD : COUNT + a
//   op 3 CSUB : COUNT - a
//   op 4 POLY : a/2 + a + a*a
//   op 5-7    : illegal, result 0 with err
//
// Ports
//   clk   rising-edge clock
//   rst   synchronous, active-high reset
//   bus   vec_op_sequencer_if.slave (start/op/a/b in, busy/done/err/result out)
//
// States
//   state  | meaning
//   IDLE   | waiting for start; latches op/a/b on accept
//   ALU    | one-cycle add/sub/constant op or illegal flagging
//   MUL    | W shift-add iterations computing a*a into acc
//   ACC    | result = acc + (a>>1) + a
//   DONE   | done pulse, busy still high; back to IDLE

module vec_op_sequencer #(
  parameter int         W     = 8,
  parameter logic [2:0] COUNT = 3'b110
) (
  input  logic               clk,
  input  logic               rst,
  vec_op_sequencer_if.slave  bus
);

  localparam int RW = 2 * W;
  localparam int IW = (W > 1) ? $clog2(W) : 1;

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_CADD = 3'd2;
  localparam logic [2:0] OP_CSUB = 3'd3;
  localparam logic [2:0] OP_POLY = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ALU  = 3'd1,
    S_MUL  = 3'd2,
    S_ACC  = 3'd3,
    S_DONE = 3'd4
  } state_e;

  state_e          state_q, state_d;

  logic [2:0]      op_q, op_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic [RW-1:0]   acc_q, acc_d;
  logic [RW-1:0]   mcand_q, mcand_d;
  logic [W-1:0]    mplier_q, mplier_d;
  logic [IW-1:0]   iter_q, iter_d;
  logic [RW-1:0]   result_q, result_d;
  logic            err_q, err_d;
  logic            done_q, done_d;

  logic            illegal;
  logic [RW-1:0]   add_x, add_y, sum;
  logic            add_ci;
  logic [W:0]      lin_term;

  assign illegal  = (op_q > OP_POLY);

  // Linear part of the poly, a/2 + a, fits in W+1 bits; it only feeds the
  // shared adder in ACC alongside the multiply accumulator.
  assign lin_term = {1'b0, a_q} + {2'b00, a_q[W-1:1]};

  // Shared adder. Subtraction is x + ~y + 1.
  assign sum = add_x + add_y + {{(RW-1){1'b0}}, add_ci};

  always_comb begin
    add_x  = '0;
    add_y  = '0;
    add_ci = 1'b0;
    case (state_q)
      S_ALU: begin
        case (op_q)
          OP_ADD: begin
            add_x = RW'(a_q);
            add_y = RW'(b_q);
          end
          OP_SUB: begin
            add_x  = RW'(b_q);
            add_y  = ~(RW'(a_q));
            add_ci = 1'b1;
          end
          OP_CADD: begin
            add_x = RW'(COUNT);
            add_y = RW'(a_q);
          end
          OP_CSUB: begin
            add_x  = RW'(COUNT);
            add_y  = ~(RW'(a_q));
            add_ci = 1'b1;
          end
          default: ;
        endcase
      end
      S_MUL: begin
        add_x = acc_q;
        add_y = mplier_q[0] ? mcand_q : '0;
      end
      S_ACC: begin
        add_x = acc_q;
        add_y = RW'(lin_term);
      end
      default: ;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = (bus.op == OP_POLY) ? S_MUL : S_ALU;
        end
      end
      S_ALU:  state_d = S_DONE;
      // iter counts down from W-1; terminal count ends the multiply
      S_MUL:  if (iter_q == '0) state_d = S_ACC;
      S_ACC:  state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath and registered-output next values
  always_comb begin
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    iter_d   = iter_q;
    result_d = result_q;
    err_d    = err_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          op_d  = bus.op;
          a_d   = bus.a;
          b_d   = bus.b;
          err_d = 1'b0;
          if (bus.op == OP_POLY) begin
            acc_d    = '0;
            mcand_d  = RW'(bus.a);
            mplier_d = bus.a;
            iter_d   = IW'(W - 1);
          end
        end
      end
      S_ALU: begin
        result_d = illegal ? '0 : sum;
        err_d    = illegal;
      end
      S_MUL: begin
        acc_d    = sum;
        mcand_d  = {mcand_q[RW-2:0], 1'b0};
        mplier_d = {1'b0, mplier_q[W-1:1]};
        iter_d   = iter_q - 1'b1;
      end
      S_ACC: begin
        result_d = sum;
        err_d    = 1'b0;
      end
      default: ;
    endcase
  end

  // done is registered: it rises on the cycle the FSM enters DONE
  assign done_d = (state_d == S_DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      iter_q   <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      iter_q   <= iter_d;
      result_q <= result_d;
      err_q    <= err_d;
      done_q   <= done_d;
    end
  end

  // Outputs
  always_comb begin
    bus.busy   = (state_q != S_IDLE);
    bus.done   = done_q;
    bus.err    = err_q;
    bus.result = result_q;
  end

endmodule

// File: tb/tb_vec_op_sequencer.sv
// tb_vec_op_sequencer
//
// Directed and randomized checks of vec_op_sequencer against an arithmetic
// reference model (result, err flag and done latency per op).

module tb_vec_op_sequencer;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  vec_op_sequencer_if #(.W(W)) vif ();

  vec_op_sequencer #(.W(W), .COUNT(3'b110)) dut (
    .clk (clk),
    .rst (rst),
    .bus (vif)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] ref_result(input int op, input int a, input int b);
    int r;
    case (op)
      0:       r = a + b;
      1:       r = b - a;
      2:       r = 6 + a;
      3:       r = 6 - a;
      4:       r = a / 2 + a + a * a;
      default: r = 0;
    endcase
    return 16'(r);
  endfunction

  function automatic int ref_latency(input int op);
    return (op == 4) ? W + 2 : 2;
  endfunction

  // Issues one request and measures posedges from the accept edge (counted
  // as 1) to the cycle where done is seen. lat=0 means no done in budget.
  task automatic do_op(input int op, input int a, input int b, input bit toggle,
                       output int lat, output logic [15:0] res, output logic e,
                       output bit busy_ok);
    @(negedge clk);
    vif.start = 1'b1;
    vif.op    = 3'(op);
    vif.a     = 8'(a);
    vif.b     = 8'(b);
    @(posedge clk); #1;
    if (!toggle) vif.start = 1'b0;
    lat = 0; res = 'x; e = 'x; busy_ok = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      if (vif.busy !== 1'b1) busy_ok = 1'b0;
      if (vif.done === 1'b1) begin
        lat = k; res = vif.result; e = vif.err;
        break;
      end
      if (toggle) begin
        vif.a = 8'($urandom);
        vif.b = 8'($urandom);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    vif.start = 1'b0; vif.op = '0; vif.a = '0; vif.b = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (vif.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", vif.busy); end
    checks++; if (vif.done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b want=0", vif.done); end
    checks++; if (vif.err !== 1'b0) begin errors++; $display("FAIL reset_err got=%b want=0", vif.err); end
    checks++; if (vif.result !== 16'h0) begin errors++; $display("FAIL reset_result got=%h want=0", vif.result); end
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (vif.busy !== 1'b0) begin errors++; $display("FAIL idle_no_start_busy got=%b want=0", vif.busy); end
  endtask

  task automatic test_alu();
    int ops [4] = '{0, 1, 3, 2};
    int as  [4] = '{200, 5, 7, 255};
    int bs  [4] = '{100, 3, 0, 0};
    logic [15:0] exp [4] = '{16'd300, 16'hFFFE, 16'hFFFF, 16'd261};
    int lat; logic [15:0] res; logic e; bit bok;
    for (int i = 0; i < 4; i++) begin
      do_op(ops[i], as[i], bs[i], 1'b0, lat, res, e, bok);
      checks++; if (lat !== 2) begin errors++; $display("FAIL alu_latency[%0d] got=%0d want=2", i, lat); end
      checks++; if (res !== exp[i]) begin errors++; $display("FAIL alu_result[%0d] got=%h want=%h", i, res, exp[i]); end
      checks++; if (e !== 1'b0) begin errors++; $display("FAIL alu_err[%0d] got=%b want=0", i, e); end
      checks++; if (bok !== 1'b1) begin errors++; $display("FAIL alu_busy[%0d] got=%b want=1", i, bok); end
      @(posedge clk); #1;
      checks++; if ({vif.done, vif.busy} !== 2'b00) begin errors++; $display("FAIL alu_after_done[%0d] done_busy=%b want=00", i, {vif.done, vif.busy}); end
      checks++; if (vif.result !== exp[i]) begin errors++; $display("FAIL alu_hold[%0d] got=%h want=%h", i, vif.result, exp[i]); end
    end
  endtask

  task automatic test_poly();
    int as [3] = '{10, 255, 0};
    logic [15:0] exp [3] = '{16'd115, 16'd65407, 16'd0};
    int lat; logic [15:0] res; logic e; bit bok;
    for (int i = 0; i < 3; i++) begin
      do_op(4, as[i], 8'hA5, 1'b0, lat, res, e, bok);
      checks++; if (lat !== 10) begin errors++; $display("FAIL poly_latency[%0d] got=%0d want=10", i, lat); end
      checks++; if (res !== exp[i]) begin errors++; $display("FAIL poly_result[%0d] got=%0d want=%0d", i, res, exp[i]); end
      checks++; if (e !== 1'b0) begin errors++; $display("FAIL poly_err[%0d] got=%b want=0", i, e); end
      checks++; if (bok !== 1'b1) begin errors++; $display("FAIL poly_busy[%0d] got=%b want=1", i, bok); end
      @(posedge clk); #1;
      checks++; if ({vif.done, vif.busy} !== 2'b00) begin errors++; $display("FAIL poly_after_done[%0d] done_busy=%b want=00", i, {vif.done, vif.busy}); end
    end
  endtask

  task automatic test_illegal();
    int lat; logic [15:0] res; logic e; bit bok;
    do_op(6, 33, 44, 1'b0, lat, res, e, bok);
    checks++; if (lat !== 2) begin errors++; $display("FAIL illegal_latency got=%0d want=2", lat); end
    checks++; if (e !== 1'b1) begin errors++; $display("FAIL illegal_err got=%b want=1", e); end
    checks++; if (res !== 16'h0) begin errors++; $display("FAIL illegal_result got=%h want=0", res); end
    @(posedge clk); #1;
    checks++; if (vif.err !== 1'b1) begin errors++; $display("FAIL illegal_err_hold got=%b want=1", vif.err); end
    do_op(0, 1, 2, 1'b0, lat, res, e, bok);
    checks++; if (e !== 1'b0) begin errors++; $display("FAIL illegal_then_add_err got=%b want=0", e); end
    checks++; if (res !== 16'd3) begin errors++; $display("FAIL illegal_then_add_result got=%0d want=3", res); end
    @(posedge clk); #1;
  endtask

  task automatic test_start_held();
    int lat; logic [15:0] res; logic e; bit bok;
    int a0 = 77;
    do_op(4, a0, 19, 1'b1, lat, res, e, bok);
    checks++; if (lat !== 10) begin errors++; $display("FAIL held_latency got=%0d want=10", lat); end
    checks++; if (res !== ref_result(4, a0, 0)) begin errors++; $display("FAIL held_result got=%0d want=%0d", res, ref_result(4, a0, 0)); end
    // start still high through DONE; queue an ADD for the first IDLE cycle
    vif.op = 3'd0; vif.a = 8'd1; vif.b = 8'd2;
    @(posedge clk); #1;
    checks++; if ({vif.done, vif.busy} !== 2'b00) begin errors++; $display("FAIL held_idle_n11 done_busy=%b want=00", {vif.done, vif.busy}); end
    @(posedge clk); #1;
    vif.start = 1'b0;
    checks++; if (vif.busy !== 1'b1) begin errors++; $display("FAIL held_accept_n11 busy=%b want=1", vif.busy); end
    @(posedge clk); #1;
    checks++; if (vif.done !== 1'b1) begin errors++; $display("FAIL held_next_done got=%b want=1", vif.done); end
    checks++; if (vif.result !== 16'd3) begin errors++; $display("FAIL held_next_result got=%0d want=3", vif.result); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_op();
    int lat; logic [15:0] res; logic e; bit bok; bit seen;
    do_op(0, 200, 100, 1'b0, lat, res, e, bok);
    checks++; if (res !== 16'd300) begin errors++; $display("FAIL abort_pre_result got=%0d want=300", res); end
    @(posedge clk); #1;
    @(negedge clk);
    vif.start = 1'b1; vif.op = 3'd4; vif.a = 8'd77;
    @(posedge clk); #1;
    vif.start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    checks++; if (vif.busy !== 1'b0) begin errors++; $display("FAIL abort_busy got=%b want=0", vif.busy); end
    checks++; if (vif.done !== 1'b0) begin errors++; $display("FAIL abort_done got=%b want=0", vif.done); end
    checks++; if (vif.result !== 16'h0) begin errors++; $display("FAIL abort_result got=%h want=0", vif.result); end
    rst = 1'b0;
    seen = 1'b0;
    repeat (15) begin
      @(posedge clk); #1;
      if (vif.done === 1'b1) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL abort_no_done got=%b want=0", seen); end
    checks++; if (vif.busy !== 1'b0) begin errors++; $display("FAIL abort_idle_busy got=%b want=0", vif.busy); end
  endtask

  task automatic test_random();
    int lat; logic [15:0] res; logic e; bit bok;
    int op, a, b;
    for (int i = 0; i < 40; i++) begin
      op = $urandom_range(0, 7);
      a  = $urandom_range(0, 255);
      b  = $urandom_range(0, 255);
      do_op(op, a, b, 1'b0, lat, res, e, bok);
      checks++; if (lat !== ref_latency(op)) begin errors++; $display("FAIL rand_latency[%0d] op=%0d got=%0d want=%0d", i, op, lat, ref_latency(op)); end
      checks++; if (res !== ref_result(op, a, b)) begin errors++; $display("FAIL rand_result[%0d] op=%0d a=%0d b=%0d got=%h want=%h", i, op, a, b, res, ref_result(op, a, b)); end
      checks++; if (e !== (op > 4)) begin errors++; $display("FAIL rand_err[%0d] op=%0d got=%b want=%b", i, op, e, (op > 4)); end
      @(posedge clk); #1;
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_poly();
    test_illegal();
    test_start_held();
    test_reset_mid_op();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
